apb_master_arbiter: RTL and testbench



---
 rtl/apb_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/apb_master_arbiter.sv | 126 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-requester APB master.
// Everything here is imported by the arbiter and the top.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWNER0,
        OWNER1
    } owner_t;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The priority pointer moves to the loser
// only when a grant is actually consumed (en).
module rr_arbiter_2 (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic valid0,
    input  logic valid1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

    // ptr = 0 gives requester 0 priority when both are valid
    logic ptr;

    assign gnt0 = valid0 && (!valid1 || !ptr);
    assign gnt1 = valid1 && (!valid0 || ptr);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ptr <= 1'b0;
        end else if (en) begin
            ptr <= gnt0;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// PREADY wait with timeout, and a one-cycle response to the winning requester.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    owner_t            owner;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err_q;
    logic              gnt0, gnt1, accept;

    rr_arbiter_2 u_arb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .en      (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    // Ready is held low while reset is asserted so no command is accepted then
    assign req0_ready = PRESETn && (state == IDLE) && gnt0;
    assign req1_ready = PRESETn && (state == IDLE) && gnt1;
    assign accept     = req0_ready || req1_ready;

    // NOTE: every output of this block gets a default first, so no latch
    // can be inferred for paths the case statement does not cover.
    always_comb begin
        state_nxt = state;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        unique case (state)
            IDLE:   if (accept) state_nxt = SETUP;
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || (cnt == CNT_LAST)) state_nxt = RESP;
            end
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            owner     <= OWNER0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_err_q <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (accept) begin
                    owner  <= gnt1 ? OWNER1 : OWNER0;
                    PWRITE <= gnt1 ? req1_write : req0_write;
                    PADDR  <= gnt1 ? req1_addr  : req0_addr;
                    PWDATA <= gnt1 ? req1_wdata : req0_wdata;
                end
                // PREADY wins over the timeout on the final ACCESS cycle
                ACCESS: if (PREADY) begin
                    rsp_data  <= PWRITE ? '0 : PRDATA;
                    rsp_err_q <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    rsp_data  <= '0;
                    rsp_err_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP:    cnt <= '0;
                default: ;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && (owner == OWNER0);
    assign rsp1_valid = (state == RESP) && (owner == OWNER1);
    assign rsp0_rdata = rsp0_valid ? rsp_data : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_data : '0;
    assign rsp0_err   = rsp0_valid && rsp_err_q;
    assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: transaction-level reference model with a simple APB
// memory slave, directed scenarios followed by randomized traffic.
module tb_apb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int STALL = 99;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          req0_valid = 1'b0, req0_write = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_write = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    function automatic logic [DW-1:0] init_pat(input int a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // APB memory slave: PREADY after cur_waits wait states in ACCESS
    logic [DW-1:0] slv_mem [0:1023];
    bit            mem_init_done = 1'b0;
    int            acc_cnt = 0;
    int            cur_waits = 0;

    assign PREADY = PSEL && PENABLE && (acc_cnt == cur_waits);
    assign PRDATA = slv_mem[PADDR[9:0]];

    always @(posedge PCLK) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) slv_mem[i] <= init_pat(i);
            mem_init_done <= 1'b1;
        end else if (PSEL && PENABLE && PREADY && PWRITE && PRESETn) begin
            slv_mem[PADDR[9:0]] <= PWDATA;
        end
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // Reference model: one outstanding transfer described by its accept edge
    // and ACCESS length; the expected bus/response timeline follows from those.
    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t          q0[$], q1[$];
    int            waits_q[$];
    bit            rand_mode = 1'b0;
    logic [DW-1:0] ref_mem [0:1023];
    bit            ptr_m = 1'b0, act = 1'b0, armed = 1'b0, t_to;
    int            t_e, t_a, t_port;
    cmd_t          t_cmd;
    logic [DW-1:0] t_rdata;
    int            cyc = 0;
    int            g_port[$], g_cyc[$];
    int            obs_rsp [2];
    logic [DW-1:0] last_rdata [2];
    logic          last_err [2];
    int            n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write = 1'($urandom_range(0, 1));
        c.addr  = AW'($urandom_range(0, 15)) << 2;
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic int rand_waits();
        int r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 18) return $urandom_range(1, 4);
        return STALL;
    endfunction

    task automatic step(input bit do_rst);
        int last;
        bit v0, v1, g0, g1, rsp_now, psel_e, pen_e;
        int w;
        @(negedge PCLK);
        last = cyc - 1;
        if (act && last == t_e + 2 + t_a) act = 1'b0;
        if (armed) begin
            psel_e  = act && last >= t_e && last <= t_e + t_a;
            pen_e   = act && last >= t_e + 1 && last <= t_e + t_a;
            rsp_now = act && last == t_e + 1 + t_a;
            check("psel", PSEL, psel_e);
            check("penable", PENABLE, pen_e);
            if (psel_e) begin
                check("paddr", PADDR, t_cmd.addr);
                check("pwrite", PWRITE, t_cmd.write);
                check("pwdata", PWDATA, t_cmd.wdata);
            end
            check("rsp0_valid", rsp0_valid, rsp_now && t_port == 0);
            check("rsp0_rdata", rsp0_rdata, (rsp_now && t_port == 0) ? t_rdata : '0);
            check("rsp0_err", rsp0_err, rsp_now && t_port == 0 && t_to);
            check("rsp1_valid", rsp1_valid, rsp_now && t_port == 1);
            check("rsp1_rdata", rsp1_rdata, (rsp_now && t_port == 1) ? t_rdata : '0);
            check("rsp1_err", rsp1_err, rsp_now && t_port == 1 && t_to);
            if (rsp0_valid) begin obs_rsp[0]++; last_rdata[0] = rsp0_rdata; last_err[0] = rsp0_err; end
            if (rsp1_valid) begin obs_rsp[1]++; last_rdata[1] = rsp1_rdata; last_err[1] = rsp1_err; end
            if (rsp_now && t_cmd.write && !t_to) ref_mem[t_cmd.addr[9:0]] = t_cmd.wdata;
        end

        if (rand_mode) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back(rand_cmd());
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) q1.push_back(rand_cmd());
        end
        v0 = (q0.size() > 0) && !(rand_mode && $urandom_range(0, 7) == 0);
        v1 = (q1.size() > 0) && !(rand_mode && $urandom_range(0, 7) == 0);
        PRESETn    = !do_rst;
        req0_valid = v0;
        req0_write = v0 ? q0[0].write : 1'($urandom_range(0, 1));
        req0_addr  = v0 ? q0[0].addr  : AW'($urandom);
        req0_wdata = v0 ? q0[0].wdata : DW'($urandom);
        req1_valid = v1;
        req1_write = v1 ? q1[0].write : 1'($urandom_range(0, 1));
        req1_addr  = v1 ? q1[0].addr  : AW'($urandom);
        req1_wdata = v1 ? q1[0].wdata : DW'($urandom);
        #1;
        g0 = !do_rst && !act && v0 && (!v1 || !ptr_m);
        g1 = !do_rst && !act && v1 && (!v0 || ptr_m);
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        if (g0 || g1) begin
            t_port = g1 ? 1 : 0;
            t_cmd  = g1 ? q1.pop_front() : q0.pop_front();
            w      = (waits_q.size() > 0) ? waits_q.pop_front() : rand_waits();
            cur_waits = w;
            t_to   = (w >= TO);
            t_a    = t_to ? TO : w + 1;
            t_e    = cyc;
            t_rdata = (t_cmd.write || t_to) ? '0 : ref_mem[t_cmd.addr[9:0]];
            act    = 1'b1;
            ptr_m  = g0;
            g_port.push_back(t_port);
            g_cyc.push_back(cyc);
        end
        if (do_rst) begin
            act   = 1'b0;
            ptr_m = 1'b0;
            armed = 1'b1;
        end
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        do begin
            step(1'b0);
            n++;
        end while ((act || q0.size() > 0 || q1.size() > 0) && n < 400);
        check({tag, "_drain"}, act || q0.size() > 0 || q1.size() > 0, 1'b0);
    endtask

    task automatic clear_logs();
        g_port.delete();
        g_cyc.delete();
        obs_rsp[0] = 0;
        obs_rsp[1] = 0;
    endtask

    function automatic cmd_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.write = wr;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_pat(i);
        step(1'b1);
        step(1'b1);
        step(1'b0);

        // single write, zero wait states
        clear_logs();
        q0.push_back(mk(1'b1, 32'h010, 32'hDEADBEEF));
        waits_q.push_back(0);
        drain("single_wr");
        check("single_wr_rsp0_count", obs_rsp[0], 1);
        check("single_wr_rsp1_count", obs_rsp[1], 0);
        check("single_wr_err", last_err[0], 1'b0);
        check("single_wr_rdata", last_rdata[0], '0);

        // write then read-back on requester 1
        clear_logs();
        q1.push_back(mk(1'b1, 32'h3FF, 32'h12345678));
        q1.push_back(mk(1'b0, 32'h3FF, 32'h0));
        waits_q.push_back(0);
        waits_q.push_back(0);
        drain("readback");
        check("readback_rdata", last_rdata[1], 32'h12345678);
        check("readback_err", last_err[1], 1'b0);

        // contention right after reset
        step(1'b1);
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk(1'b0, AW'(32'h100 + 4 * i), DW'($urandom)));
            q1.push_back(mk(1'b0, AW'(32'h200 + 4 * i), DW'($urandom)));
        end
        for (int i = 0; i < 12; i++) waits_q.push_back(0);
        drain("contention");
        check("contention_grants", g_port.size(), 12);
        for (int i = 0; i < g_port.size(); i++) begin
            check("grant_order", g_port[i], i % 2);
            if (i > 0) check("grant_spacing", g_cyc[i] - g_cyc[i-1], 4);
        end
        check("contention_rsp0_count", obs_rsp[0], 6);
        check("contention_rsp1_count", obs_rsp[1], 6);

        // wait states
        q0.push_back(mk(1'b1, 32'h040, 32'hA5A5A5A5));
        q0.push_back(mk(1'b0, 32'h040, 32'h0));
        waits_q.push_back(0);
        waits_q.push_back(3);
        drain("waits");
        check("waits_rdata", last_rdata[0], 32'hA5A5A5A5);
        check("waits_err", last_err[0], 1'b0);

        // timeout, then a normal transfer
        q1.push_back(mk(1'b0, 32'h044, 32'h0));
        waits_q.push_back(STALL);
        drain("timeout");
        check("timeout_err", last_err[1], 1'b1);
        check("timeout_rdata", last_rdata[1], '0);
        q1.push_back(mk(1'b0, 32'h040, 32'h0));
        waits_q.push_back(0);
        drain("after_timeout");
        check("after_timeout_rdata", last_rdata[1], 32'hA5A5A5A5);
        check("after_timeout_err", last_err[1], 1'b0);

        // reset during ACCESS: abort without a response, pointer back to 0
        clear_logs();
        q0.push_back(mk(1'b0, 32'h048, 32'h0));
        waits_q.push_back(STALL);
        for (int i = 0; i < 5; i++) step(1'b0);
        step(1'b1);
        step(1'b0);
        check("rst_abort_rsp_count", obs_rsp[0] + obs_rsp[1], 0);
        clear_logs();
        q0.push_back(mk(1'b0, 32'h04C, 32'h0));
        q1.push_back(mk(1'b0, 32'h050, 32'h0));
        waits_q.push_back(0);
        waits_q.push_back(0);
        drain("post_rst");
        check("post_rst_first_grant", g_port[0], 0);
        clear_logs();
        q1.push_back(mk(1'b0, 32'h054, 32'h0));
        waits_q.push_back(0);
        drain("solo1");
        check("solo1_grant", g_port[0], 1);

        // randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) step(1'b0);
        rand_mode = 1'b0;
        drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
